// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master: turns DMI read/write/nop requests into TMS/TDI bit streams for a JTAG DTM
// and returns the readback data/status taken from TDO. A request runs as an optional IR scan
// (selects DMI), a DMI write scan, an idle wait and nop readback scans that retry while busy.
// Ports: tclk/trst (clock, async active-low reset); req_valid/req_ready/req_op/req_addr/req_data
// (request handshake); rsp_valid/rsp_data/rsp_status (one-cycle response pulse, fields held);
// jtag_tms/jtag_tdi (to DTM, launched on negedge tclk); jtag_tdo (from DTM).
module jtag_dmi_master #(
  parameter int IDLE_CYCLES = 3,
  parameter int MAX_RETRIES = 8,
  parameter int ABITS       = 7
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ABITS-1:0] req_addr,
  input  logic [31:0]      req_data,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [1:0]       rsp_status,
  output logic             jtag_tms,
  output logic             jtag_tdi,
  input  logic             jtag_tdo
);

  localparam int DRLEN   = ABITS + 34;
  localparam int CNT_MAX = (IDLE_CYCLES > DRLEN + 5) ? IDLE_CYCLES : DRLEN + 5;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 2);
  localparam logic [5:0] DMI_IR = 6'h11;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PAU_DR, T_EX2_DR, T_UPD_DR,
    T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PAU_IR, T_EX2_IR, T_UPD_IR
  } tap_t;

  typedef enum logic [2:0] {
    S_RESET_TAP, S_IDLE, S_IR_SCAN, S_DR_WRITE, S_WAIT, S_DR_READ, S_RESPOND
  } state_t;

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      T_TLR:    tap_next = tms ? T_TLR    : T_RTI;
      T_RTI:    tap_next = tms ? T_SEL_DR : T_RTI;
      T_SEL_DR: tap_next = tms ? T_SEL_IR : T_CAP_DR;
      T_CAP_DR: tap_next = tms ? T_EX1_DR : T_SH_DR;
      T_SH_DR:  tap_next = tms ? T_EX1_DR : T_SH_DR;
      T_EX1_DR: tap_next = tms ? T_UPD_DR : T_PAU_DR;
      T_PAU_DR: tap_next = tms ? T_EX2_DR : T_PAU_DR;
      T_EX2_DR: tap_next = tms ? T_UPD_DR : T_SH_DR;
      T_UPD_DR: tap_next = tms ? T_SEL_DR : T_RTI;
      T_SEL_IR: tap_next = tms ? T_TLR    : T_CAP_IR;
      T_CAP_IR: tap_next = tms ? T_EX1_IR : T_SH_IR;
      T_SH_IR:  tap_next = tms ? T_EX1_IR : T_SH_IR;
      T_EX1_IR: tap_next = tms ? T_UPD_IR : T_PAU_IR;
      T_PAU_IR: tap_next = tms ? T_EX2_IR : T_PAU_IR;
      T_EX2_IR: tap_next = tms ? T_UPD_IR : T_SH_IR;
      T_UPD_IR: tap_next = tms ? T_SEL_DR : T_RTI;
      default:  tap_next = T_TLR;
    endcase
  endfunction

  state_t           state, state_n;
  tap_t             tap;
  logic [CW-1:0]    cnt, cnt_n;
  logic [RW-1:0]    retry;
  logic [1:0]       op_q;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      data_q;
  logic             ir_is_dmi;
  logic [DRLEN-1:0] sr, sr_val;
  // Only the status and data fields of the readback are kept; the address echo
  // (last ABITS bits shifted out) is not needed, so capture stops after 34 bits.
  logic [33:0]      cap;
  logic             tms_n, tdi_n, accept, ir_set, sr_load, shift_en, retry_inc, rsp_load;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    tms_n     = 1'b0;
    tdi_n     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    ir_set    = 1'b0;
    sr_load   = 1'b0;
    sr_val    = '0;
    shift_en  = 1'b0;
    retry_inc = 1'b0;
    rsp_load  = 1'b0;
    case (state)
      S_RESET_TAP: begin
        // five TMS=1 clocks guarantee Test-Logic-Reset, one TMS=0 lands in Run-Test/Idle
        tms_n = (cnt < CW'(5));
        if (cnt == CW'(5)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      S_IDLE: begin
        req_ready = 1'b1;
        cnt_n     = '0;
        if (req_valid) begin
          accept  = 1'b1;
          state_n = ir_is_dmi ? S_DR_WRITE : S_IR_SCAN;
        end
      end
      S_IR_SCAN: begin
        tms_n   = (cnt == CW'(0)) || (cnt == CW'(1)) || (cnt == CW'(9)) || (cnt == CW'(10));
        sr_load = (cnt == CW'(0));
        sr_val  = DRLEN'(DMI_IR);
        if (tap == T_SH_IR) begin
          shift_en = 1'b1;
          tdi_n    = sr[0];
        end
        if (cnt == CW'(11)) begin
          ir_set  = 1'b1;
          state_n = S_DR_WRITE;
          cnt_n   = '0;
        end
      end
      S_DR_WRITE, S_DR_READ: begin
        // cnt 0..2 walk to Shift-DR, 3..DRLEN+2 shift (TMS=1 on the last bit), then Update and Idle
        tms_n   = (cnt == CW'(0)) || (cnt == CW'(DRLEN + 2)) || (cnt == CW'(DRLEN + 3));
        sr_load = (cnt == CW'(0));
        sr_val  = (state == S_DR_WRITE) ? {addr_q, data_q, op_q} : {addr_q, 34'h0};
        if (tap == T_SH_DR) begin
          shift_en = 1'b1;
          tdi_n    = sr[0];
        end
        if (cnt == CW'(DRLEN + 4)) begin
          cnt_n = '0;
          if (state == S_DR_WRITE) begin
            state_n = S_WAIT;
          end else if (cap[1:0] == 2'b11 && retry < RW'(MAX_RETRIES)) begin
            retry_inc = 1'b1;
            state_n   = S_WAIT;
          end else begin
            rsp_load = 1'b1;
            state_n  = S_RESPOND;
          end
        end
      end
      S_WAIT: begin
        if (cnt == CW'(IDLE_CYCLES - 1)) begin
          state_n = S_DR_READ;
          cnt_n   = '0;
        end
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        state_n   = S_IDLE;
        cnt_n     = '0;
      end
      default: begin
        state_n = S_RESET_TAP;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      state      <= S_RESET_TAP;
      cnt        <= '0;
      tap        <= T_TLR;
      retry      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ir_is_dmi  <= 1'b0;
      sr         <= '0;
      cap        <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // shadow TAP follows the TMS value the real TAP samples on this edge
      tap   <= tap_next(tap, jtag_tms);
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        data_q <= req_data;
        retry  <= '0;
      end else if (retry_inc) begin
        retry <= retry + RW'(1);
      end
      if (state == S_RESET_TAP) ir_is_dmi <= 1'b0;
      else if (ir_set)          ir_is_dmi <= 1'b1;
      if (sr_load)       sr <= sr_val;
      else if (shift_en) sr <= {1'b0, sr[DRLEN-1:1]};
      if (tap == T_SH_DR && cnt < CW'(3 + 34)) cap <= {jtag_tdo, cap[33:1]};
      if (rsp_load) begin
        rsp_data   <= cap[33:2];
        rsp_status <= cap[1:0];
      end
    end
  end

  // TMS/TDI change on the falling edge so they are settled at the TAP's rising edge.
  always_ff @(negedge tclk or negedge trst) begin
    if (!trst) begin
      jtag_tms <= 1'b1;
      jtag_tdi <= 1'b0;
    end else begin
      jtag_tms <= tms_n;
      jtag_tdi <= tdi_n;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Directed bench for jtag_dmi_master with a behavioural TAP/DTM/DM model on the JTAG pins.
module tb_jtag_dmi_master;

  logic        tclk = 1'b0;
  logic        trst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        jtag_tms;
  logic        jtag_tdi;
  logic        jtag_tdo = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 tclk = ~tclk;

  jtag_dmi_master dut (
    .tclk(tclk), .trst(trst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );

  // ---------------- DTM model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
    SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
  } ts_t;

  ts_t         ts;
  logic [5:0]  ir, ir_sr;
  logic [40:0] dr;
  logic [6:0]  d_addr;
  logic [31:0] d_data;
  int          busy_cnt;
  int          dm_delay;
  int          ir_updates  = 0;
  int          nop_updates = 0;
  logic [1:0]  seen_op   = 2'd0;
  logic [6:0]  seen_addr = 7'd0;
  logic [31:0] seen_data = 32'd0;

  function automatic ts_t nxt(input ts_t s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDDR : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDDR : SHDR;
      UPDDR: return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPDIR : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPDIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  function automatic logic [31:0] rd_val(input logic [6:0] a);
    case (a)
      7'h11:   return 32'h00030382;
      7'h12:   return 32'hCAFEF00D;
      7'h13:   return 32'h13131313;
      default: return {25'h0, a};
    endcase
  endfunction

  always @(posedge tclk or negedge trst) begin
    if (!trst) begin
      ts       <= TLR;
      ir       <= 6'h01;
      ir_sr    <= 6'h00;
      dr       <= '0;
      d_addr   <= '0;
      d_data   <= '0;
      busy_cnt <= 0;
    end else begin
      ts <= nxt(ts, jtag_tms);
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      case (ts)
        TLR:   ir <= 6'h01;
        CAPIR: ir_sr <= 6'h01;
        SHIR:  ir_sr <= {jtag_tdi, ir_sr[5:1]};
        UPDIR: begin
          ir         <= ir_sr;
          ir_updates <= ir_updates + 1;
        end
        CAPDR: if (ir == 6'h11) dr <= {d_addr, d_data, (busy_cnt != 0) ? 2'b11 : 2'b00};
        SHDR:  if (ir == 6'h11) dr <= {jtag_tdi, dr[40:1]};
        UPDDR: if (ir == 6'h11) begin
          if (dr[1:0] == 2'd0) begin
            nop_updates <= nop_updates + 1;
          end else if (busy_cnt == 0) begin
            seen_op   <= dr[1:0];
            seen_addr <= dr[40:34];
            seen_data <= dr[33:2];
            d_addr    <= dr[40:34];
            d_data    <= (dr[1:0] == 2'd2) ? dr[33:2] : rd_val(dr[40:34]);
            busy_cnt  <= dm_delay;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge tclk) jtag_tdo <= dr[0];

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                        output int lat);
    int k;
    @(negedge tclk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    k = 0;
    while (!req_ready && k < 300) begin
      @(negedge tclk);
      k++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge tclk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'd3;
    req_addr  = 7'h7f;
    req_data  = $urandom;
    chk("ready_drop", req_ready, 0);
    lat = -1;
    k = 0;
    while (k < 1000) begin
      @(negedge tclk);
      if (rsp_valid) begin
        lat = k + 1;
        break;
      end
      k++;
    end
    @(negedge tclk);
    chk("rsp_pulse_one_cycle", rsp_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, ir0, nop0, hits;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_addr  = 7'd0;
    req_data  = 32'd0;
    trst      = 1'b0;
    dm_delay  = 2;

    repeat (3) @(posedge tclk);
    #1;
    chk("rst_tms", jtag_tms, 1);
    chk("rst_tdi", jtag_tdi, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    trst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge tclk);
      #1;
      chk($sformatf("reset_tms_c%0d", k), jtag_tms, (k <= 5));
      chk($sformatf("reset_ready_c%0d", k), req_ready, (k == 6));
    end
    chk("tap_in_rti", ts, RTI);
    chk("ir_idcode", ir, 6'h01);

    // first write: IR scan plus write and one readback
    ir0 = ir_updates; nop0 = nop_updates;
    do_req(2'd2, 7'h10, 32'hDEADBEEF, lat);
    chk("wr_latency", lat, 108);
    chk("wr_status", rsp_status, 0);
    chk("wr_seen_op", seen_op, 2);
    chk("wr_seen_addr", seen_addr, 7'h10);
    chk("wr_seen_data", seen_data, 32'hDEADBEEF);
    chk("wr_ir_scans", ir_updates - ir0, 1);
    chk("wr_ir_value", ir, 6'h11);
    chk("wr_readbacks", nop_updates - nop0, 1);

    // read, IR already DMI
    ir0 = ir_updates; nop0 = nop_updates;
    do_req(2'd1, 7'h11, 32'h0, lat);
    chk("rd_latency", lat, 96);
    chk("rd_data", rsp_data, 32'h00030382);
    chk("rd_status", rsp_status, 0);
    chk("rd_ir_scans", ir_updates - ir0, 0);
    chk("rd_readbacks", nop_updates - nop0, 1);

    // slow DM: three busy readbacks then success
    dm_delay = 120;
    nop0 = nop_updates;
    do_req(2'd1, 7'h12, 32'h0, lat);
    chk("slow_latency", lat, 96 + 3 * 49);
    chk("slow_data", rsp_data, 32'hCAFEF00D);
    chk("slow_status", rsp_status, 0);
    chk("slow_readbacks", nop_updates - nop0, 4);

    // reset in the middle of the DMI write scan: request dropped, IR scan redone
    dm_delay = 2;
    @(negedge tclk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h15; req_data = 32'h12345678;
    hits = 0;
    while (!req_ready && hits < 300) begin
      @(negedge tclk);
      hits++;
    end
    @(posedge tclk);
    #1;
    req_valid = 1'b0;
    repeat (20) @(posedge tclk);
    #1;
    trst = 1'b0;
    #1;
    chk("midrst_tms", jtag_tms, 1);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge tclk);
    #1;
    trst = 1'b1;
    hits = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge tclk);
      if (rsp_valid) hits++;
    end
    chk("midrst_no_rsp", hits, 0);
    chk("midrst_write_dropped", seen_addr, 7'h12);
    chk("midrst_back_idle", req_ready, 1);
    ir0 = ir_updates;
    do_req(2'd1, 7'h11, 32'h0, lat);
    chk("post_rst_latency", lat, 108);
    chk("post_rst_ir_scans", ir_updates - ir0, 1);
    chk("post_rst_data", rsp_data, 32'h00030382);

    // DM never finishes: 1 + MAX_RETRIES readbacks, busy reported
    dm_delay = 100000;
    nop0 = nop_updates;
    do_req(2'd1, 7'h13, 32'h0, lat);
    chk("busy_latency", lat, 96 + 8 * 49);
    chk("busy_status", rsp_status, 3);
    chk("busy_readbacks", nop_updates - nop0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
